// File: rtl/mux4_to_1_rr.sv
// rtl/mux4_to_1_rr.sv - round-robin 4-to-1 mux with valid/ready channels and a registered tagged output
//
// Merges four producer channels onto one registered output stream. Each
// output word carries its source channel number on S so a downstream 1-to-4
// demux can use it directly as its select.
//
// Ports:
//   Clk       clock, all state updates on the rising edge
//   Rst       synchronous active-high reset
//   Xin       channel data, channel i at Xin[i*WIDTH +: WIDTH]
//   Valid     per-channel request
//   Ready     per-channel accept, one-hot or zero
//   Yout      registered output data
//   S         registered channel tag of Yout
//   OutValid  Yout/S hold a word
//   OutReady  downstream accepts the word on Yout/S

module mux4_to_1_rr #(
    parameter int WIDTH = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [4*WIDTH-1:0] Xin,
    input  logic [3:0]         Valid,
    output logic [3:0]         Ready,
    output logic [WIDTH-1:0]   Yout,
    output logic [1:0]         S,
    output logic               OutValid,
    input  logic               OutReady
);

    // Channel that gets first look at the next grant; only moves on a grant.
    logic [1:0] ptr;

    logic       load;
    logic       found;
    logic [1:0] gnt;
    logic [1:0] idx;

    // The output register is free when empty or being drained this cycle,
    // which lets a drain and a new accept share one edge.
    assign load = !OutValid || OutReady;

    // Rotating priority search starting at ptr; first requester wins.
    always_comb begin
        found = 1'b0;
        gnt   = ptr;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && Valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Ready is held low during reset so nothing is consumed on a reset edge.
    always_comb begin
        Ready = 4'b0000;
        if (!Rst && load && found) begin
            Ready = 4'b0001 << gnt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Yout     <= '0;
            S        <= 2'b00;
            OutValid <= 1'b0;
            ptr      <= 2'b00;
        end else if (load) begin
            if (found) begin
                Yout     <= Xin[int'(gnt)*WIDTH +: WIDTH];
                S        <= gnt;
                OutValid <= 1'b1;
                ptr      <= gnt + 2'd1;
            end else begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_to_1_rr.sv
// tb/tb_mux4_to_1_rr.sv - directed self-checking bench for mux4_to_1_rr

module tb_mux4_to_1_rr;

    localparam int WIDTH = 8;

    logic               Clk;
    logic               Rst;
    logic [4*WIDTH-1:0] Xin;
    logic [3:0]         Valid;
    logic [3:0]         Ready;
    logic [WIDTH-1:0]   Yout;
    logic [1:0]         S;
    logic               OutValid;
    logic               OutReady;

    int pass_cnt = 0;
    int total    = 0;

    mux4_to_1_rr #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Xin      (Xin),
        .Valid    (Valid),
        .Ready    (Ready),
        .Yout     (Yout),
        .S        (S),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past a rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [1:0] s, input logic [7:0] y);
        chk({tag, ".ov"}, 32'(OutValid), 32'(ov));
        chk({tag, ".s"},  32'(S),        32'(s));
        chk({tag, ".y"},  32'(Yout),     32'(y));
    endtask

    logic [1:0] exp_s;
    logic [7:0] exp_y;

    initial begin
        // Reset with every channel requesting
        Rst      = 1'b1;
        Valid    = 4'b1111;
        OutReady = 1'b1;
        Xin      = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        chk("rst.ready", 32'(Ready), 32'h0);
        chk_out("rst", 1'b0, 2'd0, 8'h00);

        Rst = 1'b0;
        #1;
        chk("post_rst.ready", 32'(Ready), 32'b0001);

        // Round-robin with all valid: 0,1,2,3,0,1,2,3 back to back
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_s = 2'(i % 4);
            exp_y = 8'h11 * 8'(exp_s + 1);
            chk_out($sformatf("rr%0d", i), 1'b1, exp_s, exp_y);
            chk($sformatf("rr%0d.ready", i), 32'(Ready), 32'(4'b0001 << ((i + 1) % 4)));
        end

        // Skip and wrap: grant ch1 so the pointer lands on 2
        Valid = 4'b0010;
        #1;
        chk("skip.ready1", 32'(Ready), 32'b0010);
        tick();
        chk_out("skip.g1", 1'b1, 2'd1, 8'h22);
        Valid = 4'b0001;
        #1;
        chk("skip.ready0", 32'(Ready), 32'b0001);
        tick();
        chk_out("skip.g0", 1'b1, 2'd0, 8'h11);
        Valid = 4'b1001;
        #1;
        chk("wrap.ready3", 32'(Ready), 32'b1000);
        tick();
        chk_out("wrap.g3", 1'b1, 2'd3, 8'h44);

        // Backpressure holding an A5 word tagged 2
        Xin   = {8'h44, 8'hA5, 8'h22, 8'h11};
        Valid = 4'b0100;
        #1;
        chk("bp.ready2", 32'(Ready), 32'b0100);
        tick();
        chk_out("bp.load", 1'b1, 2'd2, 8'hA5);
        OutReady = 1'b0;
        Valid    = 4'b1111;
        #1;
        chk("bp.ready_stall", 32'(Ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("bp.hold%0d", i), 1'b1, 2'd2, 8'hA5);
            chk($sformatf("bp.hold%0d.ready", i), 32'(Ready), 32'h0);
        end
        OutReady = 1'b1;
        #1;
        chk("bp.release.ready", 32'(Ready), 32'b1000);
        tick();
        chk_out("bp.next", 1'b1, 2'd3, 8'h44);

        // Idle drain after a single ch1 word
        Valid = 4'b0010;
        #1;
        chk("idle.ready1", 32'(Ready), 32'b0010);
        tick();
        chk_out("idle.word", 1'b1, 2'd1, 8'h22);
        Valid = 4'b0000;
        #1;
        chk("idle.ready_none", 32'(Ready), 32'h0);
        tick();
        chk_out("idle.drained", 1'b0, 2'd1, 8'h22);
        tick();
        chk_out("idle.still", 1'b0, 2'd1, 8'h22);
        Valid = 4'b1111;
        #1;
        chk("idle.ptr_ready", 32'(Ready), 32'b0100);
        tick();
        chk_out("idle.g2", 1'b1, 2'd2, 8'hA5);

        // Reset while a word is stalled on the output
        OutReady = 1'b0;
        #1;
        chk("mrst.stall.ready", 32'(Ready), 32'h0);
        Rst = 1'b1;
        #1;
        chk("mrst.ready", 32'(Ready), 32'h0);
        tick();
        chk_out("mrst", 1'b0, 2'd0, 8'h00);
        Rst      = 1'b0;
        OutReady = 1'b1;
        #1;
        chk("mrst.after.ready", 32'(Ready), 32'b0001);
        tick();
        chk_out("mrst.g0", 1'b1, 2'd0, 8'h11);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mux4_to_1_rr.md
# mux4_to_1_rr

Round-robin 4-to-1 multiplexer with a valid/ready handshake on each input channel and on the output. It merges four producer channels onto one registered output stream. Each output word carries a 2-bit channel tag `S` that a downstream 1-to-4 demultiplexer uses directly as its select to route the word back to channel 0-3. One output register stage; arbitration is fair round-robin.

## Interface
- `WIDTH`, default 1: data width per channel.
- `Clk` in 1: single clock; all state updates on rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Xin` in 4*WIDTH: channel data; channel i occupies `Xin[i*WIDTH +: WIDTH]`.
- `Valid` in 4: per-channel request; bit i set means channel i holds a word.
- `Ready` out 4: per-channel accept, one-hot or zero; channel i transfers when `Valid[i] && Ready[i]`.
- `Yout` out WIDTH: registered output data.
- `S` out 2: registered channel tag of `Yout`; downstream demux select.
- `OutValid` out 1: `Yout`/`S` hold a word.
- `OutReady` in 1: downstream accepts; a transfer occurs when `OutValid && OutReady`.

## Operation
- Reset values: `Yout`=0, `S`=2'b00, `OutValid`=0, priority pointer `Ptr`=2'b00. `Ready`=4'b0000 while `Rst`=1.
- Load condition: `Load = !OutValid || OutReady`. The output register can take a new word this cycle.
- Grant is combinational. Search `Valid` in order `Ptr`, `Ptr+1`, `Ptr+2`, `Ptr+3`, all mod 4. The first set bit is the winner. `Ready` = one-hot of the winner when `Load`=1 and any `Valid` is set; otherwise 0.
- Ready depends on Valid combinationally. Producers must not make Valid depend on Ready.
- On a grant of channel g, at the clock edge:
  - `Yout` <= channel g slice.
  - `S` <= g.
  - `OutValid` <= 1.
  - `Ptr` <= g+1 (wraps 3 -> 0).
- `Load`=1 with no `Valid`: `OutValid` <= 0. `Yout`, `S` and `Ptr` hold.
- `Load`=0 (output stalled): `Yout`, `S`, `OutValid` and `Ptr` hold, and all `Ready`=0. A stalled output word never changes.
- Only one input is accepted per cycle, and only when `Ready` is asserted. A `Valid` channel not granted simply waits.
- Fairness: with all four channels continuously valid and `OutReady`=1, the grant order is 0,1,2,3,0,... A channel that is valid waits at most 3 grants.
- `Ptr` advances only on a grant, never on idle cycles.
- Reset mid-operation: a pending output word is discarded, with no transfer on the reset edge. The pointer returns to 0.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `Yout`/`S` with `OutValid`=1 after edge N.
- Full throughput: with `OutReady` held at 1, one word per cycle is sustained. Simultaneous output drain and input accept in the same cycle is required.
- Simultaneous events: `OutReady`=1 and a new grant at the same edge means the old word is consumed and the new word is loaded at that edge. No bubble, no duplicate.
- `OutReady` deasserted while `OutValid`=1: `Ready` falls to 0 in the same cycle, combinationally.
- There are no other state bits. The arbiter is stateless apart from `Ptr`.

## Test plan
- Reset: drive all `Valid`=1 with `Rst`=1 for 2 cycles -> `Ready`=0000, `OutValid`=0, `Yout`=0, `S`=00. On the first cycle after reset, `Ready`=0001.
- Round-robin (WIDTH=8): set `Xin`={8'h44,8'h33,8'h22,8'h11} (channel 3 down to 0), all `Valid`=1, `OutReady`=1 for 8 cycles -> `S` sequence 0,1,2,3,0,1,2,3 and `Yout` sequence 11,22,33,44 repeated, `OutValid` held at 1.
- Skip and wrap: `Ptr`=2 (after a grant to ch1), `Valid`=0001 -> ch0 granted, `S`=0, next `Ptr`=1. Then `Valid`=1001 -> ch3 granted before ch0.
- Backpressure: `OutValid`=1 with `Yout`=8'hA5, `S`=2, `OutReady`=0 for 5 cycles with `Valid`=1111 -> `Ready`=0000, and `Yout`/`S` stable. When `OutReady` rises, on that cycle `Ready`=1000 and the next `S`=3.
- Idle drain: single word from ch1, then `Valid`=0000 with `OutReady`=1 -> `OutValid` falls 1 cycle after the transfer. `Ptr` stays 2, so the next grant with `Valid`=1111 goes to ch2.
- Reset mid-stream: assert `Rst` while `OutValid`=1, `OutReady`=0 -> next cycle `OutValid`=0, `S`=0, and the first grant after reset goes to ch0.
